oled_text_renderer: RTL

OLED_TEXT_RENDERER -- requirements
Module: oled_text_renderer

---
 rtl/oled_text_renderer_if.sv | 26 ++
 rtl/oled_text_renderer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/oled_text_renderer_if.sv
// Request and pixel-stream handshake bundle for the OLED text renderer.
// The renderer connects to the slave modport; the requester/sink side uses master.
interface oled_text_renderer_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [23:0] i_req_text;
  logic        o_pix_valid;
  logic        i_pix_ready;
  logic [15:0] o_pix_data;
  logic        o_pix_first;
  logic        o_pix_last;
  logic        o_busy;
  logic        o_unknown_char;

  modport slave (
    input  i_req_valid, i_req_text, i_pix_ready,
    output o_req_ready, o_pix_valid, o_pix_data, o_pix_first, o_pix_last,
           o_busy, o_unknown_char
  );

  modport master (
    output i_req_valid, i_req_text, i_pix_ready,
    input  o_req_ready, o_pix_valid, o_pix_data, o_pix_first, o_pix_last,
           o_busy, o_unknown_char
  );
endinterface

// File: rtl/oled_text_renderer.sv
// Renders three ASCII characters from an 8x8 glyph ROM into a 24x8 RGB565
// pixel stream, raster order, with valid/ready flow control on the output.
module oled_text_renderer #(
  parameter logic [15:0] FG_COLOUR = 16'hFFFF,
  parameter logic [15:0] BG_COLOUR = 16'h0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  oled_text_renderer_if.slave  bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [4:0]  LAST_COL = 5'd23;
  localparam logic [2:0]  LAST_ROW = 3'd7;
  localparam logic [23:0] SPACES   = 24'h202020;

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [23:0] text_q, text_d;
  logic        unk_q, unk_d;
  logic        armed_q;

  logic        streaming;
  logic        req_ready;
  logic        accept;
  logic        at_last;
  logic [7:0]  code;
  logic [7:0]  row_bits;

  function automatic logic is_known(input logic [7:0] c);
    case (c)
      8'h20, 8'h45, 8'h47, 8'h4F, 8'h52, 8'h53: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Unsupported codes fall to the default, which is the all-clear space glyph.
  function automatic logic [7:0] glyph_row(input logic [7:0] c, input logic [2:0] r);
    logic [63:0] g;
    case (c)
      8'h45:   g = 64'h7F46_161E_1646_7F00;
      8'h47:   g = 64'h3C66_0303_7366_7C00;
      8'h4F:   g = 64'h1C36_6363_6336_1C00;
      8'h52:   g = 64'h3F66_663E_3666_6700;
      8'h53:   g = 64'h1E33_070E_3833_1E00;
      default: g = 64'h0;
    endcase
    return g[{~r, 3'b000} +: 8];
  endfunction

  assign streaming = (state_q == STREAM);
  assign req_ready = (state_q == IDLE) && armed_q;
  assign accept    = bus.i_req_valid && req_ready;
  assign at_last   = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    code = text_q[23:16];
    case (col_q[4:3])
      2'd1:    code = text_q[15:8];
      2'd2:    code = text_q[7:0];
      default: code = text_q[23:16];
    endcase
  end

  assign row_bits = glyph_row(code, row_q);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    text_d  = text_q;
    unk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          row_d   = 3'd0;
          col_d   = 5'd0;
          text_d  = bus.i_req_text;
          unk_d   = !(is_known(bus.i_req_text[23:16]) &&
                      is_known(bus.i_req_text[15:8])  &&
                      is_known(bus.i_req_text[7:0]));
        end
      end
      STREAM: begin
        if (bus.i_pix_ready) begin
          if (at_last) begin
            state_d = IDLE;
            row_d   = 3'd0;
            col_d   = 5'd0;
          end else if (col_q == LAST_COL) begin
            col_d = 5'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      col_q   <= 5'd0;
      text_q  <= SPACES;
      unk_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      text_q  <= text_d;
      unk_q   <= unk_d;
      armed_q <= 1'b1;
    end
  end

  // Outputs derive only from registered state, so they cannot move while stalled.
  assign bus.o_req_ready    = req_ready;
  assign bus.o_pix_valid    = streaming;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_unknown_char = unk_q;
  assign bus.o_pix_data     = (streaming && row_bits[col_q[2:0]]) ? FG_COLOUR : BG_COLOUR;
  assign bus.o_pix_first    = streaming && (row_q == 3'd0) && (col_q == 5'd0);
  assign bus.o_pix_last     = streaming && at_last;

endmodule
